// File: rtl/adc_pkg.sv
// Shared ADC-side definitions: sample/channel widths and the sequencing state encoding.
package adc_pkg;

  localparam int ADC_W = 12;
  localparam int CH_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } adc_state_e;

endpackage

// File: rtl/adc_window_averager_if.sv
// Sample-in / result-out bundle for the window averager.
// The master drives conversions and observes results; the slave is the averager itself.
interface adc_window_averager_if
  import adc_pkg::*;
#(
  parameter int LOG2_WIN = 4
) ();

  logic                sample_valid;
  logic [ADC_W-1:0]    sample_data;
  logic [CH_W-1:0]     sample_ch;

  logic                result_valid;
  logic [ADC_W-1:0]    result_avg;
  logic [ADC_W-1:0]    result_min;
  logic [ADC_W-1:0]    result_max;
  logic [CH_W-1:0]     result_ch;
  logic                window_abort;
  logic [LOG2_WIN:0]   sample_cnt;

  modport master (
    output sample_valid, sample_data, sample_ch,
    input  result_valid, result_avg, result_min, result_max, result_ch,
           window_abort, sample_cnt
  );

  modport slave (
    input  sample_valid, sample_data, sample_ch,
    output result_valid, result_avg, result_min, result_max, result_ch,
           window_abort, sample_cnt
  );

endinterface

// File: rtl/adc_minmax_track.sv
// Running minimum/maximum tracker. i_load restarts both extremes at i_data;
// i_update folds i_data into the current extremes. Load wins if both are set.
module adc_minmax_track
  import adc_pkg::*;
#(
  parameter int W = ADC_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_update,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_min,
  output logic [W-1:0] o_max
);

  logic [W-1:0] r_min;
  logic [W-1:0] r_max;

  // Restart or widen the running extremes on each accepted sample.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_min <= '0;
      r_max <= '0;
    end else if (i_load) begin
      r_min <= i_data;
      r_max <= i_data;
    end else if (i_update) begin
      if (i_data < r_min) r_min <= i_data;
      if (i_data > r_max) r_max <= i_data;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;

endmodule

// File: rtl/adc_window_averager.sv
// Averages ADC conversions over fixed windows of 2**LOG2_WIN samples and reports
// mean/min/max/channel with a one-cycle strobe. Partial windows are discarded on a
// channel change or when enable drops.
//
//   state | meaning
//   IDLE  | disabled; samples ignored, window cleared
//   ACCUM | collecting samples of the current window
//   DONE  | window complete; results published this cycle, next window may start
//
// The counter is cleared on the edge that accepts the final sample (rather than in
// DONE) so sample_cnt never shows 2**LOG2_WIN; the accumulator is kept for DONE.
module adc_window_averager
  import adc_pkg::*;
#(
  parameter int LOG2_WIN = 4
) (
  input  logic                  adc_clk,
  input  logic                  adc_reset_n,
  input  logic                  enable,
  adc_window_averager_if.slave  bus
);

  localparam int WIN   = 1 << LOG2_WIN;
  localparam int ACC_W = ADC_W + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

  adc_state_e         r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [CH_W-1:0]    r_cur_ch;
  logic               r_res_valid;
  logic [ADC_W-1:0]   r_res_avg;
  logic [ADC_W-1:0]   r_res_min;
  logic [ADC_W-1:0]   r_res_max;
  logic [CH_W-1:0]    r_res_ch;
  logic               r_abort;

  logic [ACC_W-1:0]   w_ext;
  logic               w_accept_accum;
  logic               w_accept_done;
  logic               w_restart;
  logic               w_last;
  logic               w_mm_load;
  logic               w_mm_update;
  logic [ADC_W-1:0]   w_min;
  logic [ADC_W-1:0]   w_max;

  assign w_ext          = {{LOG2_WIN{1'b0}}, bus.sample_data};
  assign w_accept_accum = (r_state == ACCUM) && enable && bus.sample_valid;
  assign w_accept_done  = (r_state == DONE) && enable && bus.sample_valid;
  assign w_restart      = (r_cnt == '0) || (bus.sample_ch != r_cur_ch);
  assign w_last         = !w_restart && (r_cnt == CNT_LAST);
  assign w_mm_load      = (w_accept_accum && w_restart) || w_accept_done;
  assign w_mm_update    = w_accept_accum && !w_restart;

  adc_minmax_track #(
    .W (ADC_W)
  ) u_minmax (
    .i_clk    (adc_clk),
    .i_rst_n  (adc_reset_n),
    .i_load   (w_mm_load),
    .i_update (w_mm_update),
    .i_data   (bus.sample_data),
    .o_min    (w_min),
    .o_max    (w_max)
  );

  // Window sequencing: accumulate, count, publish results and flag discarded windows.
  always_ff @(posedge adc_clk) begin
    if (!adc_reset_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_cur_ch    <= '0;
      r_res_valid <= 1'b0;
      r_res_avg   <= '0;
      r_res_min   <= '0;
      r_res_max   <= '0;
      r_res_ch    <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_abort     <= 1'b0;
      case (r_state)
        IDLE: begin
          r_acc <= '0;
          r_cnt <= '0;
          if (enable) r_state <= ACCUM;
        end
        ACCUM: begin
          if (!enable) begin
            if (r_cnt != '0) r_abort <= 1'b1;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (bus.sample_valid) begin
            if (r_cnt != '0 && bus.sample_ch != r_cur_ch) r_abort <= 1'b1;
            if (w_restart) begin
              r_acc    <= w_ext;
              r_cur_ch <= bus.sample_ch;
              r_cnt    <= CNT_W'(1);
            end else begin
              r_acc <= r_acc + w_ext;
              if (w_last) begin
                r_cnt   <= '0;
                r_state <= DONE;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
        end
        DONE: begin
          r_res_valid <= 1'b1;
          r_res_avg   <= r_acc[ACC_W-1:LOG2_WIN];
          r_res_min   <= w_min;
          r_res_max   <= w_max;
          r_res_ch    <= r_cur_ch;
          if (w_accept_done) begin
            r_acc    <= w_ext;
            r_cur_ch <= bus.sample_ch;
            r_cnt    <= CNT_W'(1);
            r_state  <= ACCUM;
          end else begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= enable ? ACCUM : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.result_valid = r_res_valid;
  assign bus.result_avg   = r_res_avg;
  assign bus.result_min   = r_res_min;
  assign bus.result_max   = r_res_max;
  assign bus.result_ch    = r_res_ch;
  assign bus.window_abort = r_abort;
  assign bus.sample_cnt   = r_cnt;

endmodule

// File: tb/tb_adc_window_averager.sv
// Directed bench for adc_window_averager with a queue-based window model checked every cycle.
module tb_adc_window_averager;
  import adc_pkg::*;

  localparam int LOG2_WIN = 4;
  localparam int N = 1 << LOG2_WIN;

  logic clk;
  logic rst_n;
  logic enable;

  adc_window_averager_if #(.LOG2_WIN(LOG2_WIN)) bus ();

  adc_window_averager #(.LOG2_WIN(LOG2_WIN)) dut (
    .adc_clk     (clk),
    .adc_reset_n (rst_n),
    .enable      (enable),
    .bus         (bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- window model ----------------
  bit model_live = 0;
  bit active = 0;
  bit pend = 0;
  int q[$];
  int qd[$];
  int q_ch = 0;
  int qd_ch = 0;
  int exp_valid = 0, exp_abort = 0, exp_cnt = 0;
  int exp_avg = 0, exp_min = 0, exp_max = 0, exp_ch = 0;

  function automatic int win_sum(input int w[$]);
    int s = 0;
    foreach (w[i]) s += w[i];
    return s;
  endfunction

  function automatic int win_min(input int w[$]);
    int m = w[0];
    foreach (w[i]) if (w[i] < m) m = w[i];
    return m;
  endfunction

  function automatic int win_max(input int w[$]);
    int m = w[0];
    foreach (w[i]) if (w[i] > m) m = w[i];
    return m;
  endfunction

  // Model: what the outputs must show after each clock edge.
  always @(posedge clk) begin
    model_live = 1;
    exp_valid = 0;
    exp_abort = 0;
    if (!rst_n) begin
      active = 0; pend = 0; q.delete();
      exp_avg = 0; exp_min = 0; exp_max = 0; exp_ch = 0;
    end else if (pend) begin
      exp_avg = win_sum(qd) / N;
      exp_min = win_min(qd);
      exp_max = win_max(qd);
      exp_ch = qd_ch;
      exp_valid = 1;
      pend = 0;
      active = enable;
      if (enable && bus.sample_valid) begin
        q.push_back(int'(bus.sample_data));
        q_ch = int'(bus.sample_ch);
      end
    end else if (!active) begin
      active = enable;
    end else if (!enable) begin
      if (q.size() > 0) exp_abort = 1;
      q.delete();
      active = 0;
    end else if (bus.sample_valid) begin
      if (q.size() > 0 && int'(bus.sample_ch) != q_ch) begin
        exp_abort = 1;
        q.delete();
      end
      if (q.size() == 0) q_ch = int'(bus.sample_ch);
      q.push_back(int'(bus.sample_data));
      if (q.size() == N) begin
        qd = q; qd_ch = q_ch; q.delete(); pend = 1;
      end
    end
    exp_cnt = q.size();
  end

  // Compare every cycle against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("result_valid", 32'(bus.result_valid), exp_valid);
      check("window_abort", 32'(bus.window_abort), exp_abort);
      check("sample_cnt", 32'(bus.sample_cnt), exp_cnt);
      check("result_avg", 32'(bus.result_avg), exp_avg);
      check("result_min", 32'(bus.result_min), exp_min);
      check("result_max", 32'(bus.result_max), exp_max);
      check("result_ch", 32'(bus.result_ch), exp_ch);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int d, input int c);
    @(negedge clk);
    bus.sample_valid = v;
    bus.sample_data  = ADC_W'(d);
    bus.sample_ch    = CH_W'(c);
  endtask

  task automatic wait_result();
    int lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.sample_valid = 1'b0;
      #1;
      if (bus.result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("result_latency", lat, 2);
  endtask

  task automatic lit_result(input string tag, input int avg, input int mn, input int mx, input int ch);
    check({tag, "_avg"}, 32'(bus.result_avg), avg);
    check({tag, "_min"}, 32'(bus.result_min), mn);
    check({tag, "_max"}, 32'(bus.result_max), mx);
    check({tag, "_ch"}, 32'(bus.result_ch), ch);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data = '0;
    bus.sample_ch = '0;
    repeat (3) @(negedge clk);
    #1;
    lit_result("reset", 0, 0, 0, 0);
    check("reset_valid", 32'(bus.result_valid), 0);
    check("reset_cnt", 32'(bus.sample_cnt), 0);

    // 1: ramp 0..15 on ch2
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 16; i++) drive(1, i, 2);
    wait_result();
    lit_result("t1", 7, 0, 15, 2);

    // 2: full-scale samples
    for (int i = 0; i < 16; i++) drive(1, 'hFFF, 2);
    wait_result();
    lit_result("t2", 'hFFF, 'hFFF, 'hFFF, 2);
    check("t2_cnt_wrap", 32'(bus.sample_cnt), 0);

    // 3: channel change after 5 samples restarts the window
    for (int i = 0; i < 5; i++) drive(1, 500, 1);
    drive(1, 10, 3);
    drive(0, 0, 0);
    #1;
    check("t3_abort", 32'(bus.window_abort), 1);
    check("t3_cnt", 32'(bus.sample_cnt), 1);
    for (int i = 1; i < 16; i++) drive(1, 10 + 10 * i, 3);
    wait_result();
    lit_result("t3", 85, 10, 160, 3);

    // 4: sample arriving in the DONE cycle opens the next window
    for (int i = 0; i < 16; i++) drive(1, 16 * i, 5);
    drive(1, 7, 5);
    drive(0, 0, 0);
    #1;
    check("t4_valid", 32'(bus.result_valid), 1);
    check("t4_cnt", 32'(bus.sample_cnt), 1);
    lit_result("t4a", 120, 0, 240, 5);
    for (int i = 1; i < 16; i++) drive(1, 7, 5);
    wait_result();
    lit_result("t4b", 7, 7, 7, 5);

    // 5: enable drops mid-window
    for (int i = 0; i < 8; i++) drive(1, 1000, 0);
    drive(0, 0, 0);
    enable = 1'b0;
    @(negedge clk);
    #1;
    check("t5_abort", 32'(bus.window_abort), 1);
    lit_result("t5_hold", 7, 7, 7, 5);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) drive(1, 'h800 + i, 4);
    wait_result();
    lit_result("t5", 'h807, 'h800, 'h80F, 4);

    // 6: reset mid-window
    for (int i = 0; i < 9; i++) drive(1, 50, 6);
    drive(0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    lit_result("t6_rst", 0, 0, 0, 0);
    check("t6_rst_cnt", 32'(bus.sample_cnt), 0);
    check("t6_rst_valid", 32'(bus.result_valid), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) drive(1, 3 * i + 1, 6);
    wait_result();
    lit_result("t6", 23, 1, 46, 6);

    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
